// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several requesters share one UART transmitter.
// A grant is held for a whole packet; a baud change is given time to settle before the first byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1024,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*2-1:0]        req_baud,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [1:0]                  baud_sel,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_done,
  output logic                        grant_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic                        lock_timeout
);

  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_LOAD,
    ST_BUSY,
    ST_HOLD
  } state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [ID_W-1:0]     grant_id_reg, grant_id_next;
  logic                grant_valid_reg, grant_valid_next;
  logic [1:0]          baud_sel_reg, baud_sel_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic                last_reg, last_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                lock_timeout_reg, lock_timeout_next;

  logic [DATA_W-1:0]   data_arr [NUM_REQ];
  logic [1:0]          baud_arr [NUM_REQ];
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic                capture;
  logic [ID_W-1:0]     capture_id;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
      assign baud_arr[gi]  = req_baud[gi*2 +: 2];
      assign req_ready[gi] = (state_reg == ST_LOAD) && (grant_id_reg == ID_W'(gi));
    end
  endgenerate

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (int'(id) >= NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  // First valid requester at or after rr_ptr; scanning downward lets the nearest one win.
  always_comb begin : p_pick
    int idx;
    logic [ID_W-1:0] cand;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    cand       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    rr_ptr_next       = rr_ptr_reg;
    grant_id_next     = grant_id_reg;
    grant_valid_next  = grant_valid_reg;
    baud_sel_next     = baud_sel_reg;
    tx_data_next      = tx_data_reg;
    last_next         = last_reg;
    cnt_next          = cnt_reg;
    lock_timeout_next = 1'b0;
    capture           = 1'b0;
    capture_id        = grant_id_reg;

    case (state_reg)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_next    = pick_id;
          grant_valid_next = 1'b1;
          if (baud_arr[pick_id] != baud_sel_reg) begin
            state_next    = ST_CONFIG;
            baud_sel_next = baud_arr[pick_id];
            cnt_next      = '0;
          end else begin
            state_next = ST_LOAD;
            capture    = 1'b1;
            capture_id = pick_id;
          end
        end
      end
      ST_CONFIG: begin
        if (cnt_reg >= CNT_W'(SETTLE_CYC - 1)) begin
          state_next = ST_LOAD;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (tx_done) begin
          if (last_reg) begin
            state_next       = ST_IDLE;
            grant_valid_next = 1'b0;
            rr_ptr_next      = next_id(grant_id_reg);
          end else begin
            state_next = ST_HOLD;
            cnt_next   = '0;
          end
        end
      end
      ST_HOLD: begin
        // The packet keeps the baud of its first byte, so no reconfiguration here.
        if (req_valid[grant_id_reg]) begin
          state_next = ST_LOAD;
          capture    = 1'b1;
        end else if (cnt_reg >= CNT_W'(TIMEOUT_CYC - 1)) begin
          state_next        = ST_IDLE;
          grant_valid_next  = 1'b0;
          rr_ptr_next       = next_id(grant_id_reg);
          lock_timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Byte and last flag are captured on the edge entering LOAD so tx_data is valid with tx_start.
    if (capture) begin
      tx_data_next = data_arr[capture_id];
      last_next    = req_last[capture_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      rr_ptr_reg       <= '0;
      grant_id_reg     <= '0;
      grant_valid_reg  <= 1'b0;
      baud_sel_reg     <= 2'd0;
      tx_data_reg      <= '0;
      last_reg         <= 1'b0;
      cnt_reg          <= '0;
      lock_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      grant_id_reg     <= grant_id_next;
      grant_valid_reg  <= grant_valid_next;
      baud_sel_reg     <= baud_sel_next;
      tx_data_reg      <= tx_data_next;
      last_reg         <= last_next;
      cnt_reg          <= cnt_next;
      lock_timeout_reg <= lock_timeout_next;
    end
  end

  assign tx_start     = (state_reg == ST_LOAD);
  assign tx_data      = tx_data_reg;
  assign baud_sel     = baud_sel_reg;
  assign grant_valid  = grant_valid_reg;
  assign grant_id     = grant_id_reg;
  assign lock_timeout = lock_timeout_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive stimulus, a monitor checks every tx_start.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*2-1:0]      req_baud;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [1:0]                baud_sel;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      grant_valid;
  logic [1:0]                grant_id;
  logic                      lock_timeout;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_baud(req_baud), .req_last(req_last),
    .req_ready(req_ready), .baud_sel(baud_sel), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .grant_valid(grant_valid), .grant_id(grant_id), .lock_timeout(lock_timeout)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] baud;
    logic       last;
  } req_item_t;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic [1:0] baud;
  } exp_t;

  req_item_t rq_q [NUM_REQ][$];
  exp_t      exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int baud_chg_cyc = 0;
  int done_cyc = 0;
  int lock_cyc = 0;
  int lock_count = 0;
  logic tx_en = 1'b1;
  logic force_done = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int i, input logic [7:0] d, input logic [1:0] b, input logic l);
    req_item_t it;
    it.data = d; it.baud = b; it.last = l;
    rq_q[i].push_back(it);
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input logic [1:0] b);
    exp_t e;
    e.id = id; e.data = d; e.baud = b;
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_valid"}, grant_valid, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_baud_sel"}, baud_sel, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_start"}, tx_start, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_lock_timeout"}, lock_timeout, 0);
  endtask

  // Requester model: presents the head of its queue, pops on acceptance.
  initial begin
    req_valid = '0; req_data = '0; req_baud = '0; req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && rq_q[i].size() > 0) void'(rq_q[i].pop_front());
        if (rq_q[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_data[i*8 +: 8]    = rq_q[i][0].data;
          req_baud[i*2 +: 2]    = rq_q[i][0].baud;
          req_last[i]           = rq_q[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Transmitter model: tx_done three cycles after tx_start.
  initial begin : tx_model
    int cnt;
    cnt = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = force_done;
      if (rst) cnt = 0;
      else if (tx_start && tx_en) cnt = 3;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done = 1'b1;
          done_cyc = cyc;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_start.
  initial begin : monitor
    logic [1:0] prev_baud;
    exp_t e;
    prev_baud = 2'd0;
    forever begin
      @(negedge clk);
      if (baud_sel !== prev_baud) baud_chg_cyc = cyc;
      prev_baud = baud_sel;
      if (lock_timeout === 1'b1) begin
        lock_count++;
        lock_cyc = cyc;
      end
      if (tx_start === 1'b1) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 1, 0);
        end else begin
          e = exp_q.pop_front();
          $display("txn cyc=%0d id=%0d data=%02h baud=%0d (exp id=%0d data=%02h baud=%0d)",
                   cyc, grant_id, tx_data, baud_sel, e.id, e.data, e.baud);
          check("grant_id", grant_id, e.id);
          check("tx_data", tx_data, e.data);
          check("baud_sel", baud_sel, e.baud);
          check("req_ready_onehot", req_ready, 4'b0001 << e.id);
          check("grant_valid_at_start", grant_valid, 1);
        end
      end else begin
        check("req_ready_outside_load", req_ready, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0;
    int base;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Single byte, no baud change: one-clock latency.
    @(posedge clk); #2;
    push_req(0, 8'h55, 2'd0, 1'b1);
    push_exp(2'd0, 8'h55, 2'd0);
    t0 = cyc;
    wait_empty("single_done", 50);
    check("min_latency", start_cyc - t0, 1);

    // All requesting: round robin 0,1,2,3,0.
    do_reset();
    @(posedge clk); #2;
    push_req(0, 8'hA0, 2'd0, 1'b1);
    push_req(0, 8'hA1, 2'd0, 1'b1);
    push_req(1, 8'hB0, 2'd0, 1'b1);
    push_req(2, 8'hC0, 2'd0, 1'b1);
    push_req(3, 8'hD0, 2'd0, 1'b1);
    push_exp(2'd0, 8'hA0, 2'd0);
    push_exp(2'd1, 8'hB0, 2'd0);
    push_exp(2'd2, 8'hC0, 2'd0);
    push_exp(2'd3, 8'hD0, 2'd0);
    push_exp(2'd0, 8'hA1, 2'd0);
    wait_empty("rr_done", 200);

    // Baud change: settle for 4 cycles, then a same-baud byte goes straight through.
    do_reset();
    @(posedge clk); #2;
    push_req(2, 8'h3C, 2'd3, 1'b1);
    push_exp(2'd2, 8'h3C, 2'd3);
    wait_empty("config_done", 60);
    check("settle_cycles", start_cyc - baud_chg_cyc, 4);
    check("baud_kept", baud_sel, 3);
    @(posedge clk); #2;
    push_req(0, 8'h5A, 2'd3, 1'b1);
    push_exp(2'd0, 8'h5A, 2'd3);
    t0 = cyc;
    wait_empty("same_baud_done", 50);
    check("no_reconfig_latency", start_cyc - t0, 1);

    // Three-byte packet keeps the lock ahead of requester 3.
    do_reset();
    @(posedge clk); #2;
    push_req(1, 8'h11, 2'd0, 1'b0);
    push_req(1, 8'h12, 2'd0, 1'b0);
    push_req(1, 8'h13, 2'd0, 1'b1);
    push_req(3, 8'h31, 2'd0, 1'b1);
    push_exp(2'd1, 8'h11, 2'd0);
    push_exp(2'd1, 8'h12, 2'd0);
    push_exp(2'd1, 8'h13, 2'd0);
    push_exp(2'd3, 8'h31, 2'd0);
    wait_empty("packet_done", 200);

    // Lock released by timeout after 1024 idle HOLD cycles.
    do_reset();
    base = lock_count;
    @(posedge clk); #2;
    push_req(0, 8'hA5, 2'd0, 1'b0);
    push_req(1, 8'hB1, 2'd0, 1'b1);
    push_exp(2'd0, 8'hA5, 2'd0);
    push_exp(2'd1, 8'hB1, 2'd0);
    n = 0;
    while (lock_count == base && n < 1500) begin
      @(negedge clk);
      n++;
    end
    check("lock_seen", lock_count - base, 1);
    check("lock_delay", lock_cyc - done_cyc, 1025);
    wait_empty("timeout_done", 100);
    check("lock_single_pulse", lock_count - base, 1);

    // Reset during BUSY; a later tx_done is ignored.
    do_reset();
    tx_en = 1'b0;
    @(posedge clk); #2;
    push_req(2, 8'h77, 2'd2, 1'b1);
    push_exp(2'd2, 8'h77, 2'd2);
    wait_empty("busy_start", 60);
    check("busy_grant_valid", grant_valid, 1);
    check("busy_baud_sel", baud_sel, 2);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #2 force_done = 1'b1;
    @(posedge clk); #2 force_done = 1'b0;
    repeat (10) @(negedge clk);
    check("post_done_grant_valid", grant_valid, 0);
    check("post_done_tx_data", tx_data, 0);
    check("post_done_baud_sel", baud_sel, 0);
    tx_en = 1'b1;

    check("lock_total", lock_count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter.
REQ-002 Parameter DATA_W, default 8: byte width.
REQ-003 Parameter SETTLE_CYC, default 4: clocks to hold off after a baud_sel change before tx_start.
REQ-004 Parameter TIMEOUT_CYC, default 1024: clocks a locked requester may stay idle between packet bytes.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester byte available.
REQ-008 req_data  in  NUM_REQ*DATA_W  per-requester byte, requester i at bits [i*DATA_W +: DATA_W].
REQ-009 req_baud  in  NUM_REQ*2  per-requester baud select (0=1200, 1=2400, 2=4800, 3=9600).
REQ-010 req_last  in  NUM_REQ  byte is last of packet; 0 keeps the grant locked.
REQ-011 req_ready  out  NUM_REQ  one-cycle acceptance pulse to the granted requester.
REQ-012 baud_sel  out  2  select to the shared baud generator.
REQ-013 tx_start  out  1  one-cycle start pulse to the transmitter.
REQ-014 tx_data  out  DATA_W  byte to transmit; valid while tx_start=1, held until next load.
REQ-015 tx_done  in  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-016 grant_valid  out  1  a requester currently owns the transmitter.
REQ-017 grant_id  out  $clog2(NUM_REQ)  index of the owning requester.
REQ-018 lock_timeout  out  1  one-cycle pulse when a lock is released by timeout.

Function
REQ-019 FSM states: IDLE, CONFIG, LOAD, BUSY, HOLD.
REQ-020 IDLE: when any req_valid=1, grant the first valid index at or after rr_ptr, wrapping modulo NUM_REQ; latch grant_id and set grant_valid on the same edge.
REQ-021 IDLE exit: go to CONFIG if req_baud of the grantee differs from baud_sel, otherwise go to LOAD.
REQ-022 CONFIG: on entry, baud_sel takes the grantee's req_baud; stay exactly SETTLE_CYC cycles, then go to LOAD.
REQ-023 LOAD: assert tx_start=1 and req_ready[grant_id]=1 for exactly one cycle; register tx_data and the grantee's req_last; go to BUSY.
REQ-024 BUSY: wait for tx_done. On tx_done, go to IDLE if the latched last=1, otherwise go to HOLD.
REQ-025 IDLE re-entry: clears grant_valid and sets rr_ptr=(grant_id+1) mod NUM_REQ.
REQ-026 HOLD: when req_valid[grant_id]=1, go to LOAD. No baud check in HOLD; the packet keeps the baud of its first byte.
REQ-027 HOLD timeout: an idle counter counts HOLD cycles. After TIMEOUT_CYC cycles without valid, pulse lock_timeout, then release as in REQ-025.
REQ-028 Other requesters' req_valid is ignored while a grant is held.
REQ-029 Minimum latency with no baud change is 1 clock: valid seen in IDLE at edge N gives tx_start at cycle N+1.
REQ-030 A tx_done outside BUSY is ignored.
REQ-031 A req_valid drop by the grantee in LOAD or BUSY does not abort the transfer; the byte is already captured.
REQ-032 At most one req_ready bit is high in any cycle, and never outside LOAD.
REQ-033 Single-requester case (NUM_REQ=1): grant_id is 1 bit wide and constant 0.

Reset
REQ-034 When rst=1 at a clock edge, the block takes: state=IDLE, rr_ptr=0, baud_sel=0, tx_data=0, grant_id=0, grant_valid=0, tx_start=0, req_ready=0, lock_timeout=0, idle counter=0.
REQ-035 Reset mid-transfer abandons the grant without a req_ready or tx_start pulse; a transfer already in flight in the transmitter is not tracked.

Verification
REQ-036 After reset, req_valid=0001, req_baud0=0, last=1, data=0x55 -> grant_id=0, tx_start one cycle later, tx_data=0x55, baud_sel stays 0.
REQ-037 req_valid=1111 held, all last=1, same baud, tx_done after each start -> grant order 0,1,2,3,0.
REQ-038 Requester 2 with baud=3 while baud_sel=0 -> baud_sel=3 on CONFIG entry, tx_start exactly 4 cycles later.
REQ-039 Requester 1 sends a 3-byte packet (last=0,0,1) while requester 3 stays valid -> three consecutive grants to 1 before any grant to 3.
REQ-040 Requester 0 sends last=0, then drops valid -> lock_timeout pulses after 1024 HOLD cycles, and requester 1 is granted next.
REQ-041 rst asserted during BUSY -> all outputs at reset values the next cycle; a following tx_done is ignored.
